// File: rtl/multi_port_adapter_if.sv
// Bus bundle for multi_port_adapter: register access handshake plus the packed
// 8-bit-per-port I/O lanes and the active-low interrupt line.
interface multi_port_adapter_if #(
   parameter int PORTS = 2
);
   logic               chip_en;
   logic               wrt_en;
   logic [3:0]         register_select;
   logic [7:0]         data_in;
   logic [7:0]         data_out;
   logic [PORTS*8-1:0] port_in;
   logic [PORTS*8-1:0] port_out;
   logic [PORTS*8-1:0] port_dir;
   logic               irqb;

   modport master (
      output chip_en, wrt_en, register_select, data_in, port_in,
      input  data_out, port_out, port_dir, irqb
   );

   modport slave (
      input  chip_en, wrt_en, register_select, data_in, port_in,
      output data_out, port_out, port_dir, irqb
   );
endinterface

// File: rtl/multi_port_adapter.sv
// Multi-port I/O adapter with output/direction registers, a 16-bit one-shot or
// free-running timer and masked interrupt flags. Define PORT_EDGE_IRQ_EN to add
// falling-edge interrupts on bit 0 of each port.
module multi_port_adapter #(
   parameter int PORTS = 2
) (
   input logic                 clk,
   input logic                 reset,
   multi_port_adapter_if.slave bus
);

   localparam logic [3:0] ADDR_T1L = 4'h8;
   localparam logic [3:0] ADDR_T1H = 4'h9;
   localparam logic [3:0] ADDR_ACR = 4'hA;
   localparam logic [3:0] ADDR_IFR = 4'hB;
   localparam logic [3:0] ADDR_IER = 4'hC;

   logic [7:0]  or_reg  [PORTS];
   logic [7:0]  ddr_reg [PORTS];
   logic [7:0]  acr;
   logic [6:0]  ifr;
   logic [6:0]  ifr_next;
   logic [6:0]  ier;
   logic [15:0] counter;
   logic [7:0]  latch_lo;
   logic [7:0]  latch_hi;
   logic        running;
   logic        wr;
   logic        t1_hi_wr;
   logic        t1_expire;
   logic        irq;
   logic [3:0]  edge_set;
   logic [7:0]  rd_data;

   assign wr        = bus.chip_en & bus.wrt_en;
   assign t1_hi_wr  = wr && (bus.register_select == ADDR_T1H);
   assign t1_expire = running && (counter == 16'h0000) && !t1_hi_wr;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PORTS; i++) begin
            or_reg[i]  <= 8'h00;
            ddr_reg[i] <= 8'h00;
         end
      end else if (wr) begin
         for (int i = 0; i < PORTS; i++) begin
            if (bus.register_select == 4'(i))
               or_reg[i] <= bus.data_in;
            if (bus.register_select == 4'(i + 4))
               ddr_reg[i] <= bus.data_in;
         end
      end
   end

`ifdef PORT_EDGE_IRQ_EN
   logic [PORTS-1:0] pin_prev;

   always_ff @(posedge clk) begin
      if (reset)
         pin_prev <= '0;
      else
         for (int i = 0; i < PORTS; i++)
            pin_prev[i] <= bus.port_in[8*i];
   end

   always_comb begin
      edge_set = 4'b0000;
      for (int i = 0; i < PORTS; i++)
         edge_set[i] = pin_prev[i] & ~bus.port_in[8*i];
   end
`else
   assign edge_set = 4'b0000;
`endif

   // A T1_HI write owns IFR[6] for that edge; otherwise set events beat clears.
   always_comb begin
      ifr_next = ifr;
      if (wr && (bus.register_select == ADDR_IFR))
         ifr_next = ifr & ~bus.data_in[6:0];
      ifr_next[6]   = ifr_next[6] | t1_expire;
      ifr_next[3:0] = ifr_next[3:0] | edge_set;
      if (t1_hi_wr)
         ifr_next[6] = 1'b0;
`ifndef PORT_EDGE_IRQ_EN
      ifr_next[3:0] = 4'b0000;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acr <= 8'h00;
         ifr <= 7'h00;
         ier <= 7'h00;
      end else begin
         ifr <= ifr_next;
         if (wr && (bus.register_select == ADDR_ACR))
            acr <= bus.data_in;
         if (wr && (bus.register_select == ADDR_IER)) begin
            if (bus.data_in[7])
               ier <= ier | bus.data_in[6:0];
            else
               ier <= ier & ~bus.data_in[6:0];
         end
      end
   end

   // Expiry at zero either reloads from the latch (free-run) or stops the timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         counter  <= 16'h0000;
         latch_lo <= 8'hFF;
         latch_hi <= 8'hFF;
         running  <= 1'b0;
      end else begin
         if (wr && (bus.register_select == ADDR_T1L))
            latch_lo <= bus.data_in;
         if (t1_hi_wr) begin
            latch_hi <= bus.data_in;
            counter  <= {bus.data_in, latch_lo};
            running  <= 1'b1;
         end else if (running) begin
            if (counter != 16'h0000)
               counter <= counter - 16'd1;
            else if (acr[0])
               counter <= {latch_hi, latch_lo};
            else
               running <= 1'b0;
         end
      end
   end

   assign irq = |(ifr & ier);

   always_comb begin
      rd_data = 8'h00;
      if (bus.chip_en) begin
         for (int i = 0; i < PORTS; i++) begin
            if (bus.register_select == 4'(i))
               rd_data = (or_reg[i] & ddr_reg[i]) | (bus.port_in[8*i +: 8] & ~ddr_reg[i]);
            if (bus.register_select == 4'(i + 4))
               rd_data = ddr_reg[i];
         end
         case (bus.register_select)
            ADDR_T1L: rd_data = counter[7:0];
            ADDR_T1H: rd_data = counter[15:8];
            ADDR_ACR: rd_data = acr;
            ADDR_IFR: rd_data = {irq, ifr};
            ADDR_IER: rd_data = {1'b1, ier};
            default:  ;
         endcase
      end
   end

   assign bus.data_out = rd_data;
   assign bus.irqb     = ~irq;

   for (genvar g = 0; g < PORTS; g++) begin : g_port
      assign bus.port_out[8*g +: 8] = or_reg[g];
      assign bus.port_dir[8*g +: 8] = ddr_reg[g];
   end

endmodule

// File: tb/tb_multi_port_adapter.sv
// Scoreboard bench for multi_port_adapter: stimulus queues expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_multi_port_adapter;

   localparam int PORTS = 2;
   localparam int K_DATA = 0;
   localparam int K_IRQB = 1;
   localparam int K_POUT = 2;
   localparam int K_PDIR = 3;

   logic clk;
   logic reset;

   multi_port_adapter_if #(.PORTS(PORTS)) bus ();

   multi_port_adapter #(.PORTS(PORTS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          kind_q [$];
   logic [31:0] exp_q  [$];
   string       name_q [$];
   int          checks;
   int          errors;

   int          mon_kind;
   logic [31:0] mon_exp;
   logic [31:0] mon_act;
   string       mon_name;

   // Monitor: everything queued during the current cycle is compared here.
   always @(negedge clk) begin
      while (kind_q.size() > 0) begin
         mon_kind = kind_q.pop_front();
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         case (mon_kind)
            K_DATA:  mon_act = {24'h0, bus.data_out};
            K_IRQB:  mon_act = {31'h0, bus.irqb};
            K_POUT:  mon_act = 32'(bus.port_out);
            default: mon_act = 32'(bus.port_dir);
         endcase
         checks++;
         if (mon_act !== mon_exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", mon_name, mon_act, mon_exp);
         end
      end
   end

   task automatic applyStimulus(input logic ce, input logic we,
                                input logic [3:0] sel, input logic [7:0] din);
      bus.chip_en         = ce;
      bus.wrt_en          = we;
      bus.register_select = sel;
      bus.data_in         = din;
   endtask

   task automatic checkOutput(input int kind, input logic [31:0] exp, input string name);
      kind_q.push_back(kind);
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
         next_cycle();
      end
   endtask

   task automatic do_write(input logic [3:0] sel, input logic [7:0] din);
      applyStimulus(1'b1, 1'b1, sel, din);
      next_cycle();
   endtask

   task automatic do_read(input logic [3:0] sel, input logic [7:0] exp, input string name);
      applyStimulus(1'b1, 1'b0, sel, 8'h00);
      checkOutput(K_DATA, {24'h0, exp}, name);
      next_cycle();
   endtask

   task automatic read_irq(input logic [3:0] sel, input logic [7:0] exp,
                           input logic irqb_exp, input string name);
      applyStimulus(1'b1, 1'b0, sel, 8'h00);
      checkOutput(K_DATA, {24'h0, exp}, name);
      checkOutput(K_IRQB, {31'h0, irqb_exp}, {name, "_irqb"});
      next_cycle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.port_in = 16'h0000;
      applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
      next_cycle();
      next_cycle();
      reset = 1'b0;

      // Reset state
      checkOutput(K_POUT, 32'h0, "rst_port_out");
      checkOutput(K_PDIR, 32'h0, "rst_port_dir");
      read_irq(4'hB, 8'h00, 1'b1, "rst_ifr");
      do_read(4'hC, 8'h80, "rst_ier");
      do_read(4'h8, 8'h00, "rst_t1l");
      do_read(4'h9, 8'h00, "rst_t1h");
      do_read(4'hA, 8'h00, "rst_acr");
      applyStimulus(1'b0, 1'b0, 4'hC, 8'h00);
      checkOutput(K_DATA, 32'h0, "chip_disabled_read");
      next_cycle();

      // Port direction/output registers and mixed read-back
      bus.port_in = 16'h5A3C;
      do_write(4'h4, 8'hF0);
      do_write(4'h0, 8'hA5);
      checkOutput(K_POUT, 32'h00A5, "port_out_or0");
      checkOutput(K_PDIR, 32'h00F0, "port_dir_ddr0");
      do_read(4'h0, 8'hAC, "or0_read");
      do_write(4'h5, 8'h0F);
      do_write(4'h1, 8'hFF);
      checkOutput(K_POUT, 32'hFFA5, "port_out_or1");
      checkOutput(K_PDIR, 32'h0FF0, "port_dir_ddr1");
      do_read(4'h1, 8'h5F, "or1_read");
      do_write(4'h2, 8'h77);
      do_read(4'h2, 8'h00, "or2_absent");
      do_read(4'h6, 8'h00, "ddr2_absent");
      do_read(4'hD, 8'h00, "addr_d_unmapped");
      do_read(4'hF, 8'h00, "addr_f_unmapped");

      // One-shot timer: latch 3 expires 4 cycles after the T1_HI write
      do_write(4'hC, 8'hC0);
      do_read(4'hC, 8'hC0, "ier_set6");
      do_write(4'h8, 8'h03);
      do_write(4'hA, 8'h00);
      do_write(4'h9, 8'h00);
      do_read(4'h8, 8'h03, "os_cnt3");
      do_read(4'h8, 8'h02, "os_cnt2");
      do_read(4'h8, 8'h01, "os_cnt1");
      read_irq(4'hB, 8'h00, 1'b1, "os_before_exp");
      read_irq(4'hB, 8'hC0, 1'b0, "os_expired");
      do_read(4'h8, 8'h00, "os_hold_lo");
      do_read(4'h9, 8'h00, "os_hold_hi");
      idle(3);
      do_read(4'h8, 8'h00, "os_still_held");

      // Free-running timer with clear and re-expiry
      do_write(4'hB, 8'h40);
      read_irq(4'hB, 8'h00, 1'b1, "ifr_cleared");
      do_write(4'hA, 8'h01);
      do_write(4'h9, 8'h00);
      idle(3);
      read_irq(4'hB, 8'h00, 1'b1, "fr_before_exp");
      read_irq(4'hB, 8'hC0, 1'b0, "fr_exp1");
      do_write(4'hB, 8'h40);
      read_irq(4'hB, 8'h00, 1'b1, "fr_clr_next");
      read_irq(4'hB, 8'h00, 1'b1, "fr_pre_exp2");
      read_irq(4'hB, 8'hC0, 1'b0, "fr_exp2");

      // Clear coinciding with expiry: set wins
      idle(2);
      do_write(4'hB, 8'h40);
      read_irq(4'hB, 8'hC0, 1'b0, "clr_vs_exp");
      // T1_HI write coinciding with expiry: write wins, counter reloaded
      idle(2);
      do_write(4'h9, 8'h01);
      read_irq(4'hB, 8'h00, 1'b1, "t1h_vs_exp");
      do_read(4'h9, 8'h01, "t1h_reload_hi");
      do_read(4'h8, 8'h01, "t1h_reload_lo");

      // Reset mid-count (counter 0x0010) also overrides a simultaneous write
      do_write(4'h8, 8'h10);
      do_write(4'h9, 8'h00);
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 4'h0, 8'h55);
      next_cycle();
      reset = 1'b0;
      checkOutput(K_POUT, 32'h0, "mid_rst_port_out");
      checkOutput(K_PDIR, 32'h0, "mid_rst_port_dir");
      read_irq(4'h8, 8'h00, 1'b1, "mid_rst_cnt_lo");
      do_read(4'h9, 8'h00, "mid_rst_cnt_hi");
      do_read(4'hB, 8'h00, "mid_rst_ifr");
      do_read(4'hC, 8'h80, "mid_rst_ier");
      do_read(4'hA, 8'h00, "mid_rst_acr");
      do_read(4'h0, 8'h3C, "mid_rst_or0");
      idle(20);
      read_irq(4'hB, 8'h00, 1'b1, "mid_rst_no_exp");
      do_write(4'h9, 8'h00);
      do_read(4'h8, 8'hFF, "rst_latch_lo");

      // Port bit-0 falling edge
      do_write(4'hC, 8'h81);
      do_read(4'hC, 8'h81, "ier_81");
      bus.port_in = 16'h5A3D;
      idle(2);
      bus.port_in = 16'h5A3C;
      idle(2);
`ifdef PORT_EDGE_IRQ_EN
      read_irq(4'hB, 8'h81, 1'b0, "edge_irq");
`else
      read_irq(4'hB, 8'h00, 1'b1, "edge_irq");
`endif
      do_write(4'hC, 8'h01);
      read_irq(4'hC, 8'h80, 1'b1, "ier_clear0");

      idle(1);
      if (kind_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d expected 0", kind_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
